aq_f_spsram_1024x64_ctrl: RTL and testbench

- Request-side controller placed directly upstream of the 1024x64 single-port SRAM macro.
- Converts a valid/ready read/write request stream with byte masks into the macro's active-low CEN/GWEN/bit-WEN pin protocol.
- Captures read data into a 2-entry response buffer that supports consumer backpressure.
- After reset, optionally zero-fills the whole array before it accepts traffic.

---
 rtl/aq_f_spsram_ctrl_pkg.sv | 15 +
 rtl/aq_f_spsram_rsp_fifo.sv | 65 ++++++
 rtl/aq_f_spsram_rsp_fifo_chk.sv | 19 +
 rtl/aq_f_spsram_1024x64_ctrl.sv | 137 +++++++++++++
 tb/tb_aq_f_spsram_1024x64_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aq_f_spsram_ctrl_pkg.sv
// Shared defaults, FSM encoding and response-buffer sizing for the
// 1024x64 single-port SRAM request controller.
package aq_f_spsram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_DATA_WIDTH = 64;
  localparam int unsigned RSP_FIFO_DEPTH = 2;
  localparam int unsigned RSP_CNT_W      = $clog2(RSP_FIFO_DEPTH + 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/aq_f_spsram_rsp_fifo.sv
// Two-entry flop FIFO holding SRAM read data until the consumer takes it.
module aq_f_spsram_rsp_fifo
  import aq_f_spsram_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head_data,
  output logic [RSP_CNT_W-1:0] count,
  output logic                 empty
);

  localparam int unsigned PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

  logic [WIDTH-1:0]     mem_q [RSP_FIFO_DEPTH];
  logic [WIDTH-1:0]     mem_d [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [RSP_CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    cnt_d = cnt_q + RSP_CNT_W'(push) - RSP_CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(RSP_FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = cnt_q;
  assign empty     = (cnt_q == '0);

endmodule

// File: rtl/aq_f_spsram_rsp_fifo_chk.sv
// Occupancy checks for the response FIFO; the request credit rule must
// keep it from ever overflowing or being popped while empty.
module aq_f_spsram_rsp_fifo_chk
  import aq_f_spsram_ctrl_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  input logic                 push,
  input logic                 pop,
  input logic [RSP_CNT_W-1:0] count
);

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == RSP_CNT_W'(RSP_FIFO_DEPTH))));

  no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && (count == '0)));

endmodule

// File: rtl/aq_f_spsram_1024x64_ctrl.sv
// Request-side controller for the 1024x64 single-port SRAM: zero-fill after
// reset, valid/ready to CEN/GWEN/WEN translation, buffered read responses.
module aq_f_spsram_1024x64_ctrl
  import aq_f_spsram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit          INIT_EN    = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req_vld,
  output logic                    req_rdy,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_bmask,
  output logic                    rsp_vld,
  input  logic                    rsp_rdy,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    init_done,
  output logic [ADDR_WIDTH-1:0]   ram_a,
  output logic                    ram_cen,
  output logic                    ram_gwen,
  output logic [DATA_WIDTH-1:0]   ram_wen,
  output logic [DATA_WIDTH-1:0]   ram_d,
  input  logic [DATA_WIDTH-1:0]   ram_q
);

  localparam int          NUM_BYTES = int'(DATA_WIDTH / 8);
  localparam int unsigned CRD_W     = RSP_CNT_W + 1;
  localparam ctrl_state_e RST_STATE = INIT_EN ? ST_INIT : ST_RUN;

  ctrl_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  fire_s, pop_s, fifo_empty_s;
  logic [RSP_CNT_W-1:0]  fifo_cnt_s;
  logic [CRD_W-1:0]      credit_s;

  // Outstanding reads (in flight plus buffered, less this cycle's pop) gate new requests.
  always_comb begin
    rsp_vld   = ~RST & ~fifo_empty_s;
    pop_s     = rsp_vld & rsp_rdy;
    credit_s  = CRD_W'(rd_pend_q) + CRD_W'(fifo_cnt_s) - CRD_W'(pop_s);
    init_done = ~RST & (state_q == ST_RUN);
    req_rdy   = init_done & (credit_s < CRD_W'(RSP_FIFO_DEPTH));
    fire_s    = req_vld & req_rdy;
  end

  always_comb begin
    ram_cen  = 1'b1;
    ram_gwen = 1'b1;
    ram_wen  = '1;
    ram_a    = '0;
    ram_d    = '0;
    if (!RST && (state_q == ST_INIT)) begin
      ram_cen  = 1'b0;
      ram_gwen = 1'b0;
      ram_wen  = '0;
      ram_a    = init_cnt_q;
      ram_d    = '0;
    end else if (fire_s && req_wr) begin
      ram_cen  = 1'b0;
      ram_gwen = 1'b0;
      ram_a    = req_addr;
      ram_d    = req_wdata;
      for (int b = 0; b < NUM_BYTES; b++) ram_wen[8*b +: 8] = {8{~req_bmask[b]}};
    end else if (fire_s) begin
      ram_cen  = 1'b0;
      ram_gwen = 1'b1;
      ram_wen  = '1;
      ram_a    = req_addr;
      ram_d    = '0;
    end else begin
      ram_cen  = 1'b1;
      ram_gwen = 1'b1;
      ram_wen  = '1;
      ram_a    = '0;
      ram_d    = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == '1) state_d = ST_RUN;
        else                  state_d = ST_INIT;
      end
      ST_RUN: begin
        state_d    = ST_RUN;
        init_cnt_d = init_cnt_q;
      end
      default: begin
        state_d    = RST_STATE;
        init_cnt_d = '0;
      end
    endcase
    rd_pend_d = fire_s & ~req_wr;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= RST_STATE;
      init_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  // ram_q is valid the cycle after a read was issued, which is exactly when rd_pend is set.
  aq_f_spsram_rsp_fifo #(.WIDTH(DATA_WIDTH)) u_rsp_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (rd_pend_q),
    .push_data (ram_q),
    .pop       (pop_s),
    .head_data (rsp_rdata),
    .count     (fifo_cnt_s),
    .empty     (fifo_empty_s)
  );

  aq_f_spsram_rsp_fifo_chk u_rsp_fifo_chk (
    .clk   (CLK),
    .rst   (RST),
    .push  (rd_pend_q),
    .pop   (pop_s),
    .count (fifo_cnt_s)
  );

endmodule

// File: tb/tb_aq_f_spsram_1024x64_ctrl.sv
// Self-checking bench: SRAM macro model, queue-based reference scoreboard,
// vector table for pin mapping and directed multi-cycle sequences.
module tb_aq_f_spsram_1024x64_ctrl;

  localparam int AW = 10;
  localparam int DW = 64;
  localparam int NB = 8;
  localparam int DEPTH = 1 << AW;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_vld, req_rdy, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [NB-1:0] req_bmask;
  logic          rsp_vld, rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic [AW-1:0] ram_a;
  logic          ram_cen, ram_gwen;
  logic [DW-1:0] ram_wen, ram_d;
  logic [DW-1:0] ram_q = '0;

  int n_checks = 0;
  int n_errors = 0;

  aq_f_spsram_1024x64_ctrl dut (
    .CLK(CLK), .RST(RST),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_bmask(req_bmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .ram_a(ram_a), .ram_cen(ram_cen), .ram_gwen(ram_gwen), .ram_wen(ram_wen),
    .ram_d(ram_d), .ram_q(ram_q)
  );

  always #5 CLK = ~CLK;

  // SRAM macro model: per-bit active-low write enables, read data one cycle later.
  logic [DW-1:0] sram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) sram[i] = {$urandom, $urandom} | 64'h1;
  always @(posedge CLK) begin
    if (!ram_cen) begin
      if (!ram_gwen) sram[ram_a] <= (sram[ram_a] & ram_wen) | (ram_d & ~ram_wen);
      else           ram_q <= sram[ram_a];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_pins(input string tag, input logic cen, input logic gwen,
                            input logic [63:0] wen, input logic [AW-1:0] a,
                            input logic chk_d, input logic [63:0] d);
    check({tag, "_cen"}, 64'(ram_cen), 64'(cen));
    check({tag, "_gwen"}, 64'(ram_gwen), 64'(gwen));
    check({tag, "_wen"}, ram_wen, wen);
    check({tag, "_a"}, 64'(ram_a), 64'(a));
    if (chk_d) check({tag, "_d"}, ram_d, d);
  endtask

  // Reference model: array contents plus a queue of expected responses with due cycles.
  typedef struct { logic [63:0] data; int due; } rsp_t;
  rsp_t          exp_q[$];
  logic [DW-1:0] ref_arr [DEPTH];
  int            cyc = 0;
  int            since_rst = 0;

  always @(negedge CLK) begin
    logic exp_vld, pop, fire;
    int   nq;
    cyc++;
    if (RST) begin
      exp_q.delete();
      since_rst = 0;
      check("rst_rsp_vld", 64'(rsp_vld), 64'd0);
      check("rst_req_rdy", 64'(req_rdy), 64'd0);
      check("rst_init_done", 64'(init_done), 64'd0);
      check_pins("rst_pins", 1'b1, 1'b1, ALL1, '0, 1'b1, 64'd0);
    end else if (since_rst < DEPTH) begin
      check("fill_init_done", 64'(init_done), 64'd0);
      check("fill_req_rdy", 64'(req_rdy), 64'd0);
      check("fill_rsp_vld", 64'(rsp_vld), 64'd0);
      check_pins("fill_pins", 1'b0, 1'b0, 64'd0, AW'(since_rst), 1'b1, 64'd0);
      since_rst++;
    end else begin
      if (since_rst == DEPTH) foreach (ref_arr[i]) ref_arr[i] = '0;
      since_rst++;
      check("run_init_done", 64'(init_done), 64'd1);
      exp_vld = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
      check("mon_rsp_vld", 64'(rsp_vld), 64'(exp_vld));
      if (exp_vld) check("mon_rsp_rdata", rsp_rdata, exp_q[0].data);
      pop = exp_vld && rsp_rdy;
      nq  = exp_q.size() - (pop ? 1 : 0);
      check("mon_req_rdy", 64'(req_rdy), 64'(nq < 2));
      fire = req_vld && req_rdy;
      if (pop) void'(exp_q.pop_front());
      if (fire && req_wr) begin
        check("mon_wr_cen", 64'(ram_cen), 64'd0);
        check("mon_wr_gwen", 64'(ram_gwen), 64'd0);
        check("mon_wr_a", 64'(ram_a), 64'(req_addr));
        check("mon_wr_d", ram_d, req_wdata);
        for (int b = 0; b < NB; b++)
          if (req_bmask[b]) ref_arr[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
      end else if (fire) begin
        check_pins("mon_rd", 1'b0, 1'b1, ALL1, req_addr, 1'b0, 64'd0);
        exp_q.push_back('{data: ref_arr[req_addr], due: cyc + 2});
      end else begin
        check_pins("mon_idle", 1'b1, 1'b1, ALL1, '0, 1'b1, 64'd0);
      end
    end
  end

  typedef struct {
    logic        vld, wr;
    logic [9:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  bmask;
    logic        exp_cen, exp_gwen;
    logic [63:0] exp_wen;
    logic [9:0]  exp_a;
    logic        chk_d;
    logic [63:0] exp_d;
  } vec_t;
  vec_t vecs[6];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic vld, input logic wr, input logic [AW-1:0] a,
                       input logic [63:0] d, input logic [7:0] m);
    req_vld = vld; req_wr = wr; req_addr = a; req_wdata = d; req_bmask = m;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [63:0] d,
                            input logic [7:0] m, input string name);
    drive(1'b1, 1'b1, a, d, m);
    @(negedge CLK);
    check({name, "_rdy"}, 64'(req_rdy), 64'd1);
    step();
    drive(1'b0, 1'b0, '0, 64'd0, 8'd0);
  endtask

  task automatic read_expect(input logic [AW-1:0] a, input logic [63:0] exp, input string name);
    drive(1'b1, 1'b0, a, 64'd0, 8'd0);
    @(negedge CLK);
    check({name, "_rdy"}, 64'(req_rdy), 64'd1);
    step();
    drive(1'b0, 1'b0, '0, 64'd0, 8'd0);
    @(negedge CLK);
    check({name, "_lat1_vld"}, 64'(rsp_vld), 64'd0);
    step();
    @(negedge CLK);
    check({name, "_vld"}, 64'(rsp_vld), 64'd1);
    check({name, "_data"}, rsp_rdata, exp);
    step();
  endtask

  initial begin
    int cnt, issued, got;
    vecs[0] = '{1'b1, 1'b1, 10'h3FF, 64'h0123_4567_89AB_CDEF, 8'h0F, 1'b0, 1'b0,
                64'hFFFF_FFFF_0000_0000, 10'h3FF, 1'b1, 64'h0123_4567_89AB_CDEF};
    vecs[1] = '{1'b1, 1'b1, 10'h001, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 1'b0, 1'b0,
                64'h0, 10'h001, 1'b1, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[2] = '{1'b1, 1'b1, 10'h002, 64'h1111_2222_3333_4444, 8'h00, 1'b0, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 10'h002, 1'b1, 64'h1111_2222_3333_4444};
    vecs[3] = '{1'b1, 1'b1, 10'h155, 64'hA5A5_A5A5_A5A5_A5A5, 8'h81, 1'b0, 1'b0,
                64'h00FF_FFFF_FFFF_FF00, 10'h155, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5};
    vecs[4] = '{1'b1, 1'b0, 10'h3FF, 64'hFFFF_0000_FFFF_0000, 8'hFF, 1'b0, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 10'h3FF, 1'b0, 64'h0};
    vecs[5] = '{1'b0, 1'b1, 10'h2AA, 64'h5555_5555_5555_5555, 8'hFF, 1'b1, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 10'h000, 1'b1, 64'h0};

    RST = 1'b1;
    rsp_rdy = 1'b1;
    drive(1'b0, 1'b0, '0, 64'd0, 8'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Zero-fill: count the cycles before init_done rises.
    cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge CLK);
      if (init_done) break;
      cnt++;
    end
    check("init_cycles", 64'(cnt), 64'd1024);
    step();

    // Pin mapping vectors.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].vld, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].bmask);
      @(negedge CLK);
      check($sformatf("vec%0d_rdy", i), 64'(req_rdy), 64'd1);
      check_pins($sformatf("vec%0d", i), vecs[i].exp_cen, vecs[i].exp_gwen, vecs[i].exp_wen,
                 vecs[i].exp_a, vecs[i].chk_d, vecs[i].exp_d);
      step();
    end
    drive(1'b0, 1'b0, '0, 64'd0, 8'd0);
    repeat (3) step();
    read_expect(10'h3FF, 64'h0000_0000_89AB_CDEF, "masked_rd");

    // Back-to-back reads with rsp_rdy held high.
    for (int i = 0; i < 8; i++) write_word(AW'(i), 64'(i), 8'hFF, "pre_wr");
    for (int k = 0; k < 10; k++) begin
      if (k < 8) drive(1'b1, 1'b0, AW'(k), 64'd0, 8'd0);
      else       drive(1'b0, 1'b0, '0, 64'd0, 8'd0);
      @(negedge CLK);
      if (k < 8) check("b2b_rdy", 64'(req_rdy), 64'd1);
      if (k >= 2) begin
        check("b2b_vld", 64'(rsp_vld), 64'd1);
        check("b2b_data", rsp_rdata, 64'(k - 2));
      end else begin
        check("b2b_early_vld", 64'(rsp_vld), 64'd0);
      end
      step();
    end

    // Backpressure: only two reads may be outstanding.
    rsp_rdy = 1'b0;
    issued = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, AW'(issued), 64'd0, 8'd0);
      @(negedge CLK);
      if (req_rdy) issued++;
      step();
    end
    drive(1'b1, 1'b0, AW'(issued), 64'd0, 8'd0);
    @(negedge CLK);
    check("bp_fired", 64'(issued), 64'd2);
    check("bp_rdy_low", 64'(req_rdy), 64'd0);
    check("bp_vld", 64'(rsp_vld), 64'd1);
    check("bp_head", rsp_rdata, 64'd0);
    step();
    rsp_rdy = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !(got == 4 && issued == 4); c++) begin
      if (issued < 4) drive(1'b1, 1'b0, AW'(issued), 64'd0, 8'd0);
      else            drive(1'b0, 1'b0, '0, 64'd0, 8'd0);
      @(negedge CLK);
      if (rsp_vld && rsp_rdy) begin
        check("bp_order", rsp_rdata, 64'(got));
        got++;
      end
      if (req_vld && req_rdy) issued++;
      step();
    end
    drive(1'b0, 1'b0, '0, 64'd0, 8'd0);
    check("bp_issued", 64'(issued), 64'd4);
    check("bp_got", 64'(got), 64'd4);
    step();

    // Write followed immediately by a read of the same word, then a zero-mask write.
    write_word(10'd5, 64'hAA, 8'hFF, "hz_wr");
    read_expect(10'd5, 64'hAA, "hz_rd");
    write_word(10'd5, 64'h55, 8'h00, "zm_wr");
    read_expect(10'd5, 64'hAA, "zm_rd");

    // Random traffic against the scoreboard.
    for (int c = 0; c < 800; c++) begin
      drive($urandom_range(9, 0) < 7, 1'($urandom), AW'($urandom_range(15, 0)),
            {$urandom, $urandom}, 8'($urandom));
      rsp_rdy = $urandom_range(9, 0) < 6;
      step();
    end
    drive(1'b0, 1'b0, '0, 64'd0, 8'd0);
    rsp_rdy = 1'b1;
    repeat (5) step();

    // Reset with one response buffered and another in flight.
    rsp_rdy = 1'b0;
    drive(1'b1, 1'b0, 10'd0, 64'd0, 8'd0);
    @(negedge CLK);
    check("mr_rd0_rdy", 64'(req_rdy), 64'd1);
    step();
    drive(1'b1, 1'b0, 10'd1, 64'd0, 8'd0);
    @(negedge CLK);
    check("mr_rd1_rdy", 64'(req_rdy), 64'd1);
    step();
    drive(1'b0, 1'b0, '0, 64'd0, 8'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("mr_rst_vld", 64'(rsp_vld), 64'd0);
    check_pins("mr_rst_pins", 1'b1, 1'b1, ALL1, '0, 1'b1, 64'd0);
    step();
    @(negedge CLK);
    check("mr_rst2_vld", 64'(rsp_vld), 64'd0);
    check_pins("mr_rst2_pins", 1'b1, 1'b1, ALL1, '0, 1'b1, 64'd0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    check("mr_post_vld", 64'(rsp_vld), 64'd0);
    check_pins("mr_refill", 1'b0, 1'b0, 64'd0, '0, 1'b1, 64'd0);
    for (int i = 0; i < 1100 && !init_done; i++) @(negedge CLK);
    check("mr_reinit_done", 64'(init_done), 64'd1);
    rsp_rdy = 1'b1;
    step();
    read_expect(10'h3FF, 64'd0, "mr_zero_rd");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
